p4_router_egress_demux: RTL and testbench
=========================================

Name: p4_router_egress_demux

Overview:
- Sits downstream of the VNP4 P4 router wrapper and consumes its output stream plus per-packet user metadata.
- Queues the metadata and steers each packet to one of NUM_EGR_PORTS egress AXIS masters, using the already-mapped RTL egress index.
- Drops packets whose egress index is out of range (including 0xFF) and counts them.

Parameters:
- NUM_EGR_PORTS, 11, number of egress AXIS masters; RTL egress index 0..NUM_EGR_PORTS-1.
- EGR_SPEC_ID_WIDTH, 8, width of egress field, user_metadata_in[EGR_SPEC_ID_WIDTH-1:0].
- ING_PORT_ID_WIDTH, 8, width of ingress field, directly above the egress field.
- USER_METADATA_WIDTH, EGR_SPEC_ID_WIDTH+ING_PORT_ID_WIDTH, total metadata width.
- META_FIFO_DEPTH, 4, metadata queue entries; power of two, >=2.

Ports:
- clk  in  1  single block clock; all interfaces synchronous to it.
- aresetn  in  1  asynchronous active-low reset.
- data_in  AXIS_int.Slave  64b tdata/8b tkeep  packet stream from VNP4.
- user_metadata_in  in  USER_METADATA_WIDTH  {ing_port_id, egr_spec}.
- user_metadata_in_valid  in  1  one-cycle pulse, exactly once per packet, at or before the first beat.
- data_out[NUM_EGR_PORTS]  AXIS_int.Master  64b/8b  egress streams.
- ing_port_id_out  out  ING_PORT_ID_WIDTH  ingress id of the packet currently forwarded.
- drop_count  out  32  saturating count of dropped packets.
- meta_overflow  out  1  sticky: metadata arrived while queue full.

Behaviour:
- Reset (async assert, sync deassert by the integrator): FSM=IDLE, queue empty, data_in.tready=0, all data_out tvalid=0, drop_count=0, meta_overflow=0, ing_port_id_out=0.
- Metadata capture:
  - Push on every user_metadata_in_valid, regardless of tready.
  - If the queue is full and no pop happens that cycle: discard the entry and set meta_overflow (cleared only by reset).
  - If the queue is full with a push and a pop in the same cycle: accept the push; occupancy is unchanged.
- FSM:
  - IDLE: data_in.tready=0. If the queue is non-empty, register sel=head egr_spec and ing_port_id_out=head ingress field, then go to FWD if sel<NUM_EGR_PORTS, else DROP. Otherwise stay in IDLE.
  - FWD: combinational pass-through. data_out[sel] tdata/tkeep/tlast/tvalid = data_in; data_in.tready = data_out[sel].tready. All other ports have tvalid=0. On an accepted beat with tlast=1: pop the queue, go to IDLE.
  - DROP: data_in.tready=1 and no output tvalid. On an accepted tlast beat: pop the queue, drop_count+=1 (saturates at 0xFFFFFFFF), go to IDLE.
- Latency: zero cycles data path in FWD. One bubble cycle (IDLE) per packet, so back-to-back packets cost one extra cycle.
- Metadata arriving in the same cycle as the first beat while in IDLE with an empty queue:
  - It is visible in the queue on the next cycle.
  - The decision is made the cycle after that.
  - The beat is held by tready=0 in the meantime; no data is lost.
- Once sel is latched, the output tdata/tkeep/tlast are stable while tvalid is high (AXIS rule is inherited from the upstream source). sel never changes mid-packet.
- A single-beat packet (tlast on the first beat) is valid and is handled identically.
- Reset mid-packet: the downstream packet is truncated (tvalid drops without tlast) and the metadata queue is flushed. This is accepted behaviour; downstream recovers on the next tlast.

Decomposition:
- p4_router_pkg holds:
  - RTL egress/ingress index enums (CPU, OISL0/1, ECP0/1, HDR0/1, ECG0..3);
  - P4 port id constants;
  - the metadata field widths and the packed metadata struct (egress in LSBs).
- Sub-module p4_router_meta_fifo: sync FIFO with first-word-fall-through, clk/aresetn, push/pop/full/empty, parameterised width and depth.

Test Plan:
- Port-select sweep: metadata egr=0 then egr=7, each with a 3-beat packet and all tready=1 → packet appears only on data_out[0], then only on data_out[7]; bytes and tkeep match; one idle cycle between packets.
- Drop: egr=0xFF, 5-beat packet → no output tvalid; data_in accepts 5 beats; drop_count 0→1. Repeat with egr=11 → drop_count=2.
- Backpressure: egr=3; data_out[3].tready toggles 1,0,0,1 → data_in.tready mirrors it; no beat lost or duplicated; other ports stay at tvalid=0.
- Queue full: send 5 metadata pulses with data stalled, META_FIFO_DEPTH=4 → meta_overflow=1 after the 5th pulse. Releasing data forwards 4 packets in order. Also cover push+pop in the same cycle while full → no overflow.
- Reset: assert aresetn=0 mid 4-beat packet on port 2 → all tvalid=0 immediately; after release, a new egr=1 packet forwards correctly and drop_count=0.
- Single-beat packets: 3 back-to-back tlast-only packets to ports 1,2,1 → each delivered with a one-cycle gap; ing_port_id_out updates per packet.

Source files
------------

// File: rtl/p4_router_pkg.sv
// rtl/p4_router_pkg.sv - shared types and constants for the P4 router egress path
package p4_router_pkg;

   localparam int P4_EGR_SPEC_ID_W   = 8;
   localparam int P4_ING_PORT_ID_W   = 8;
   localparam int P4_USER_META_W     = P4_EGR_SPEC_ID_W + P4_ING_PORT_ID_W;
   localparam int P4_NUM_EGR_PORTS   = 11;
   localparam int P4_META_FIFO_DEPTH = 4;
   localparam int P4_AXIS_DATA_W     = 64;
   localparam int P4_AXIS_KEEP_W     = P4_AXIS_DATA_W / 8;

   // RTL egress index: position of the AXIS master in the data_out array
   typedef enum logic [P4_EGR_SPEC_ID_W-1:0] {
      EGR_CPU   = 8'd0,
      EGR_OISL0 = 8'd1,
      EGR_OISL1 = 8'd2,
      EGR_ECP0  = 8'd3,
      EGR_ECP1  = 8'd4,
      EGR_HDR0  = 8'd5,
      EGR_HDR1  = 8'd6,
      EGR_ECG0  = 8'd7,
      EGR_ECG1  = 8'd8,
      EGR_ECG2  = 8'd9,
      EGR_ECG3  = 8'd10
   } rtl_egr_idx_e;

   typedef enum logic [P4_ING_PORT_ID_W-1:0] {
      ING_CPU   = 8'd0,
      ING_OISL0 = 8'd1,
      ING_OISL1 = 8'd2,
      ING_ECP0  = 8'd3,
      ING_ECP1  = 8'd4,
      ING_HDR0  = 8'd5,
      ING_HDR1  = 8'd6,
      ING_ECG0  = 8'd7,
      ING_ECG1  = 8'd8,
      ING_ECG2  = 8'd9,
      ING_ECG3  = 8'd10
   } rtl_ing_idx_e;

   // Port numbers as seen by the P4 program, before mapping to RTL indices
   localparam logic [7:0] P4_PORT_CPU   = 8'h00;
   localparam logic [7:0] P4_PORT_OISL0 = 8'h10;
   localparam logic [7:0] P4_PORT_OISL1 = 8'h11;
   localparam logic [7:0] P4_PORT_ECP0  = 8'h20;
   localparam logic [7:0] P4_PORT_ECP1  = 8'h21;
   localparam logic [7:0] P4_PORT_HDR0  = 8'h30;
   localparam logic [7:0] P4_PORT_HDR1  = 8'h31;
   localparam logic [7:0] P4_PORT_ECG0  = 8'h40;
   localparam logic [7:0] P4_PORT_ECG1  = 8'h41;
   localparam logic [7:0] P4_PORT_ECG2  = 8'h42;
   localparam logic [7:0] P4_PORT_ECG3  = 8'h43;
   localparam logic [7:0] P4_PORT_DROP  = 8'hFF;

   typedef struct packed {
      logic [P4_ING_PORT_ID_W-1:0] ing_port_id;
      logic [P4_EGR_SPEC_ID_W-1:0] egr_spec;
   } user_metadata_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_FWD  = 2'd1,
      ST_DROP = 2'd2
   } demux_state_e;

endpackage

// File: rtl/p4_router_meta_fifo.sv
// rtl/p4_router_meta_fifo.sv - first-word-fall-through metadata queue
module p4_router_meta_fifo #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             aresetn,
   input  logic             push_i,
   input  logic [WIDTH-1:0] data_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] data_o,
   output logic             full_o,
   output logic             empty_o
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    rd_q, wr_q;
   logic [AW:0]      cnt_q;
   logic             do_push, do_pop;

   assign full_o  = (cnt_q == (AW+1)'(DEPTH));
   assign empty_o = (cnt_q == '0);
   assign do_pop  = pop_i && !empty_o;
   // A push into a full queue is only taken when the head leaves in the same cycle
   assign do_push = push_i && (!full_o || do_pop);
   assign data_o  = mem_q[rd_q];

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem_q[wr_q] <= data_i;
      end
   end

   always_ff @(posedge clk or negedge aresetn) begin
      if (!aresetn) begin
         rd_q  <= '0;
         wr_q  <= '0;
         cnt_q <= '0;
      end else begin
         if (do_push) begin
            wr_q <= wr_q + AW'(1);
         end
         if (do_pop) begin
            rd_q <= rd_q + AW'(1);
         end
         cnt_q <= cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
      end
   end

endmodule

// File: rtl/p4_router_egress_demux.sv
// rtl/p4_router_egress_demux.sv - steers VNP4 output packets to egress AXIS masters by metadata
module p4_router_egress_demux
   import p4_router_pkg::*;
#(
   parameter int NUM_EGR_PORTS       = P4_NUM_EGR_PORTS,
   parameter int EGR_SPEC_ID_WIDTH   = P4_EGR_SPEC_ID_W,
   parameter int ING_PORT_ID_WIDTH   = P4_ING_PORT_ID_W,
   parameter int USER_METADATA_WIDTH = EGR_SPEC_ID_WIDTH + ING_PORT_ID_WIDTH,
   parameter int META_FIFO_DEPTH     = P4_META_FIFO_DEPTH
) (
   input  logic                                 clk,
   input  logic                                 aresetn,
   input  logic [63:0]                          data_in_tdata,
   input  logic [7:0]                           data_in_tkeep,
   input  logic                                 data_in_tlast,
   input  logic                                 data_in_tvalid,
   output logic                                 data_in_tready,
   input  logic [USER_METADATA_WIDTH-1:0]       user_metadata_in,
   input  logic                                 user_metadata_in_valid,
   output logic [NUM_EGR_PORTS-1:0][63:0]       data_out_tdata,
   output logic [NUM_EGR_PORTS-1:0][7:0]        data_out_tkeep,
   output logic [NUM_EGR_PORTS-1:0]             data_out_tlast,
   output logic [NUM_EGR_PORTS-1:0]             data_out_tvalid,
   input  logic [NUM_EGR_PORTS-1:0]             data_out_tready,
   output logic [ING_PORT_ID_WIDTH-1:0]         ing_port_id_out,
   output logic [31:0]                          drop_count,
   output logic                                 meta_overflow
);

   demux_state_e                   state_q, state_d;
   logic [EGR_SPEC_ID_WIDTH-1:0]   sel_q, sel_d;
   logic [ING_PORT_ID_WIDTH-1:0]   ing_q, ing_d;
   logic [31:0]                    drop_q, drop_d;
   logic                           ovf_q, ovf_d;

   logic [USER_METADATA_WIDTH-1:0] head;
   logic [EGR_SPEC_ID_WIDTH-1:0]   head_egr;
   logic [ING_PORT_ID_WIDTH-1:0]   head_ing;
   logic                           fifo_full, fifo_empty, fifo_pop;
   logic                           sel_tready;

   p4_router_meta_fifo #(
      .WIDTH (USER_METADATA_WIDTH),
      .DEPTH (META_FIFO_DEPTH)
   ) u_meta_fifo (
      .clk     (clk),
      .aresetn (aresetn),
      .push_i  (user_metadata_in_valid),
      .data_i  (user_metadata_in),
      .pop_i   (fifo_pop),
      .data_o  (head),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   assign head_egr = head[EGR_SPEC_ID_WIDTH-1:0];
   assign head_ing = head[USER_METADATA_WIDTH-1:EGR_SPEC_ID_WIDTH];

   // Payload is broadcast; only the selected port's tvalid qualifies it
   assign data_out_tdata = {NUM_EGR_PORTS{data_in_tdata}};
   assign data_out_tkeep = {NUM_EGR_PORTS{data_in_tkeep}};
   assign data_out_tlast = {NUM_EGR_PORTS{data_in_tlast}};

   assign ing_port_id_out = ing_q;
   assign drop_count      = drop_q;
   assign meta_overflow   = ovf_q;

   always_comb begin
      sel_tready = 1'b0;
      for (int i = 0; i < NUM_EGR_PORTS; i++) begin
         if (sel_q == EGR_SPEC_ID_WIDTH'(i)) begin
            sel_tready = data_out_tready[i];
         end
      end
   end

   always_comb begin
      state_d         = state_q;
      sel_d           = sel_q;
      ing_d           = ing_q;
      drop_d          = drop_q;
      fifo_pop        = 1'b0;
      data_in_tready  = 1'b0;
      data_out_tvalid = '0;
      unique case (state_q)
         ST_IDLE: begin
            if (!fifo_empty) begin
               sel_d   = head_egr;
               ing_d   = head_ing;
               state_d = (32'(head_egr) < 32'(NUM_EGR_PORTS)) ? ST_FWD : ST_DROP;
            end
         end
         ST_FWD: begin
            data_in_tready = sel_tready;
            for (int i = 0; i < NUM_EGR_PORTS; i++) begin
               if (sel_q == EGR_SPEC_ID_WIDTH'(i)) begin
                  data_out_tvalid[i] = data_in_tvalid;
               end
            end
            if (data_in_tvalid && sel_tready && data_in_tlast) begin
               fifo_pop = 1'b1;
               state_d  = ST_IDLE;
            end
         end
         ST_DROP: begin
            data_in_tready = 1'b1;
            if (data_in_tvalid && data_in_tlast) begin
               fifo_pop = 1'b1;
               state_d  = ST_IDLE;
               if (drop_q != 32'hFFFF_FFFF) begin
                  drop_d = drop_q + 32'd1;
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Overflow only when the full queue cannot free a slot this cycle
   assign ovf_d = ovf_q | (user_metadata_in_valid && fifo_full && !fifo_pop);

   always_ff @(posedge clk or negedge aresetn) begin
      if (!aresetn) begin
         state_q <= ST_IDLE;
         sel_q   <= '0;
         ing_q   <= '0;
         drop_q  <= '0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         sel_q   <= sel_d;
         ing_q   <= ing_d;
         drop_q  <= drop_d;
         ovf_q   <= ovf_d;
      end
   end

endmodule

// File: tb/tb_p4_router_egress_demux.sv
// tb/tb_p4_router_egress_demux.sv - directed self-checking bench for p4_router_egress_demux
module tb_p4_router_egress_demux;

   localparam int NP = 11;

   logic                 clk;
   logic                 aresetn;
   logic [63:0]          data_in_tdata;
   logic [7:0]           data_in_tkeep;
   logic                 data_in_tlast;
   logic                 data_in_tvalid;
   logic                 data_in_tready;
   logic [15:0]          user_metadata_in;
   logic                 user_metadata_in_valid;
   logic [NP-1:0][63:0]  data_out_tdata;
   logic [NP-1:0][7:0]   data_out_tkeep;
   logic [NP-1:0]        data_out_tlast;
   logic [NP-1:0]        data_out_tvalid;
   logic [NP-1:0]        data_out_tready;
   logic [7:0]           ing_port_id_out;
   logic [31:0]          drop_count;
   logic                 meta_overflow;

   p4_router_egress_demux dut (
      .clk                    (clk),
      .aresetn                (aresetn),
      .data_in_tdata          (data_in_tdata),
      .data_in_tkeep          (data_in_tkeep),
      .data_in_tlast          (data_in_tlast),
      .data_in_tvalid         (data_in_tvalid),
      .data_in_tready         (data_in_tready),
      .user_metadata_in       (user_metadata_in),
      .user_metadata_in_valid (user_metadata_in_valid),
      .data_out_tdata         (data_out_tdata),
      .data_out_tkeep         (data_out_tkeep),
      .data_out_tlast         (data_out_tlast),
      .data_out_tvalid        (data_out_tvalid),
      .data_out_tready        (data_out_tready),
      .ing_port_id_out        (ing_port_id_out),
      .drop_count             (drop_count),
      .meta_overflow          (meta_overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int         port;
      logic [63:0] d;
      logic [7:0] k;
      logic       l;
      logic [7:0] ing;
      int         cyc;
   } obs_t;

   typedef struct {
      logic [7:0] egr;
      logic [7:0] ing;
      int         nbeats;
      int         exp_port;
      int         exp_drop;
   } vec_t;

   obs_t        obs_q[$];
   int          checks, errors, cyc;
   int          in_acc, multi_v, mirror_err, stall_cnt, nv;
   logic [15:0] bp_pat;
   int          bp_idx;
   vec_t        vecs[6];

   always @(posedge clk) cyc = cyc + 1;

   always @(negedge clk) begin
      obs_t o;
      nv = 0;
      for (int j = 0; j < NP; j++) begin
         if (data_out_tvalid[j]) begin
            nv++;
            if (data_in_tready !== data_out_tready[j]) mirror_err++;
            if (!data_out_tready[j]) stall_cnt++;
            else begin
               o.port = j; o.d = data_out_tdata[j]; o.k = data_out_tkeep[j];
               o.l = data_out_tlast[j]; o.ing = ing_port_id_out; o.cyc = cyc;
               obs_q.push_back(o);
            end
         end
      end
      if (nv > 1) multi_v++;
      if (data_in_tvalid && data_in_tready) in_acc++;
   end

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   function automatic logic [63:0] beat_data(input logic [7:0] egr, input logic [7:0] ing, input int b);
      return {8'hA5, ing, egr, 8'(b), 32'h600D_0000 + 32'(b)};
   endfunction

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic meta_pulse(input logic [7:0] egr, input logic [7:0] ing);
      user_metadata_in       = {ing, egr};
      user_metadata_in_valid = 1'b1;
      step(1);
      user_metadata_in_valid = 1'b0;
   endtask

   // Drives beats 0..n-1; stops early with beat max_acc presented when max_acc >= 0
   task automatic drive_pkt(input logic [7:0] egr, input logic [7:0] ing, input int n,
                            input bit with_meta, input int max_acc);
      int t;
      bit hs;
      for (int b = 0; b < n; b++) begin
         data_in_tvalid = 1'b1;
         data_in_tdata  = beat_data(egr, ing, b);
         data_in_tkeep  = (b == n-1) ? 8'h0F : 8'hFF;
         data_in_tlast  = (b == n-1);
         if (b == max_acc) return;
         if (with_meta && b == 0) begin
            user_metadata_in       = {ing, egr};
            user_metadata_in_valid = 1'b1;
         end
         t  = 0;
         hs = 1'b0;
         while (!hs && t < 40) begin
            data_out_tready = {NP{bp_pat[bp_idx % 16]}};
            bp_idx++;
            @(negedge clk);
            hs = data_in_tvalid && data_in_tready;
            step(1);
            user_metadata_in_valid = 1'b0;
            t++;
         end
         if (!hs) begin
            checks++;
            errors++;
            $display("FAIL beat_timeout: egr %0h beat %0d not accepted, required accept within 40 cycles", egr, b);
            data_in_tvalid = 1'b0;
            return;
         end
      end
      data_in_tvalid = 1'b0;
      data_in_tlast  = 1'b0;
   endtask

   task automatic check_obs(input string nm, input int first, input int port,
                            input logic [7:0] egr, input logic [7:0] ing, input int n);
      int bad;
      int idx;
      bad = 0;
      for (int b = 0; b < n; b++) begin
         idx = first + b;
         if (idx >= obs_q.size()) bad++;
         else if (obs_q[idx].port != port || obs_q[idx].d !== beat_data(egr, ing, b) ||
                  obs_q[idx].k !== ((b == n-1) ? 8'h0F : 8'hFF) || obs_q[idx].l !== (b == n-1) ||
                  obs_q[idx].ing !== ing) bad++;
      end
      chk(nm, 64'(bad), 64'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      checks = 0; errors = 0; cyc = 0;
      in_acc = 0; multi_v = 0; mirror_err = 0; stall_cnt = 0;
      bp_pat = 16'hFFFF; bp_idx = 0;
      aresetn = 1'b0;
      data_in_tdata = '0; data_in_tkeep = '0; data_in_tlast = 1'b0; data_in_tvalid = 1'b0;
      user_metadata_in = '0; user_metadata_in_valid = 1'b0;
      data_out_tready = '1;

      vecs[0] = '{8'd0,   8'h11, 3, 0,  0};
      vecs[1] = '{8'd7,   8'h22, 3, 7,  0};
      vecs[2] = '{8'hFF,  8'h33, 5, -1, 1};
      vecs[3] = '{8'd11,  8'h44, 5, -1, 2};
      vecs[4] = '{8'd10,  8'h55, 1, 10, 2};
      vecs[5] = '{8'd5,   8'h66, 2, 5,  2};

      step(3);
      chk("rst_tready", data_in_tready, 0);
      chk("rst_tvalid", data_out_tvalid, 0);
      chk("rst_drop_count", drop_count, 0);
      chk("rst_overflow", meta_overflow, 0);
      chk("rst_ing", ing_port_id_out, 0);
      aresetn = 1'b1;
      step(2);

      for (int v = 0; v < 6; v++) begin
         obs_q.delete(); in_acc = 0; multi_v = 0;
         drive_pkt(vecs[v].egr, vecs[v].ing, vecs[v].nbeats, 1'b1, -1);
         step(1);
         chk($sformatf("vec%0d_out_beats", v), obs_q.size(),
             (vecs[v].exp_port < 0) ? 0 : vecs[v].nbeats);
         if (vecs[v].exp_port >= 0)
            check_obs($sformatf("vec%0d_data", v), 0, vecs[v].exp_port, vecs[v].egr, vecs[v].ing, vecs[v].nbeats);
         chk($sformatf("vec%0d_in_beats", v), in_acc, vecs[v].nbeats);
         chk($sformatf("vec%0d_drop_count", v), drop_count, vecs[v].exp_drop);
         chk($sformatf("vec%0d_ing", v), ing_port_id_out, vecs[v].ing);
         chk($sformatf("vec%0d_one_port", v), multi_v, 0);
      end

      // backpressure on port 3: tready 1,0,0,1,1,...
      obs_q.delete(); in_acc = 0; multi_v = 0; mirror_err = 0; stall_cnt = 0;
      meta_pulse(8'd3, 8'h77);
      step(1);
      bp_pat = 16'hFFF9; bp_idx = 0;
      drive_pkt(8'd3, 8'h77, 4, 1'b0, -1);
      bp_pat = 16'hFFFF;
      data_out_tready = '1;
      step(1);
      chk("bp_out_beats", obs_q.size(), 4);
      check_obs("bp_data", 0, 3, 8'd3, 8'h77, 4);
      chk("bp_in_beats", in_acc, 4);
      chk("bp_tready_mirror", mirror_err, 0);
      chk("bp_stall_cycles", stall_cnt, 2);
      chk("bp_one_port", multi_v, 0);

      // full queue with push and pop in the same cycle
      obs_q.delete();
      for (int k = 1; k <= 4; k++) meta_pulse(8'(k), 8'hB0 + 8'(k));
      user_metadata_in       = {8'hB5, 8'd5};
      user_metadata_in_valid = 1'b1;
      drive_pkt(8'd1, 8'hB1, 1, 1'b0, -1);
      chk("pushpop_no_overflow", meta_overflow, 0);
      for (int k = 2; k <= 5; k++) drive_pkt(8'(k), 8'hB0 + 8'(k), 1, 1'b0, -1);
      step(1);
      chk("pushpop_out_beats", obs_q.size(), 5);
      for (int k = 1; k <= 5; k++)
         check_obs($sformatf("pushpop_pkt%0d", k), k-1, k, 8'(k), 8'hB0 + 8'(k), 1);

      // overflow: fifth pulse into a full queue is discarded
      obs_q.delete();
      for (int k = 1; k <= 4; k++) meta_pulse(8'(k), 8'hC0 + 8'(k));
      chk("ovf_before_5th", meta_overflow, 0);
      meta_pulse(8'd6, 8'hC6);
      chk("ovf_after_5th", meta_overflow, 1);
      for (int k = 1; k <= 4; k++) drive_pkt(8'(k), 8'hC0 + 8'(k), 2, 1'b0, -1);
      step(1);
      chk("ovf_out_beats", obs_q.size(), 8);
      for (int k = 1; k <= 4; k++)
         check_obs($sformatf("ovf_pkt%0d", k), 2*(k-1), k, 8'(k), 8'hC0 + 8'(k), 2);
      in_acc = 0;
      data_in_tvalid = 1'b1; data_in_tlast = 1'b1;
      step(5);
      chk("ovf_queue_drained", in_acc, 0);
      data_in_tvalid = 1'b0; data_in_tlast = 1'b0;

      // reset in the middle of a 4-beat packet on port 2
      obs_q.delete();
      drive_pkt(8'd2, 8'hD2, 4, 1'b1, 2);
      #2;
      aresetn = 1'b0;
      #1;
      chk("midrst_tvalid", data_out_tvalid, 0);
      chk("midrst_tready", data_in_tready, 0);
      chk("midrst_partial_beats", obs_q.size(), 2);
      @(posedge clk); #1;
      aresetn = 1'b1;
      data_in_tvalid = 1'b0;
      step(1);
      chk("midrst_drop_count", drop_count, 0);
      chk("midrst_overflow", meta_overflow, 0);
      chk("midrst_ing", ing_port_id_out, 0);
      obs_q.delete(); in_acc = 0;
      drive_pkt(8'd1, 8'hE1, 3, 1'b1, -1);
      step(1);
      chk("postrst_out_beats", obs_q.size(), 3);
      check_obs("postrst_data", 0, 1, 8'd1, 8'hE1, 3);
      chk("postrst_in_beats", in_acc, 3);

      // back-to-back single-beat packets to ports 1,2,1
      obs_q.delete();
      meta_pulse(8'd1, 8'hA1);
      meta_pulse(8'd2, 8'hA2);
      meta_pulse(8'd1, 8'hA3);
      drive_pkt(8'd1, 8'hA1, 1, 1'b0, -1);
      drive_pkt(8'd2, 8'hA2, 1, 1'b0, -1);
      drive_pkt(8'd1, 8'hA3, 1, 1'b0, -1);
      step(1);
      chk("single_out_beats", obs_q.size(), 3);
      check_obs("single_pkt0", 0, 1, 8'd1, 8'hA1, 1);
      check_obs("single_pkt1", 1, 2, 8'd2, 8'hA2, 1);
      check_obs("single_pkt2", 2, 1, 8'd1, 8'hA3, 1);
      if (obs_q.size() == 3) begin
         chk("single_gap01", obs_q[1].cyc - obs_q[0].cyc, 2);
         chk("single_gap12", obs_q[2].cyc - obs_q[1].cyc, 2);
      end
      chk("single_drop_count", drop_count, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
